// File: rtl/mips32_core.sv
// Single-cycle MIPS-I integer subset: fetch, decode, execute, memory and
// write-back all complete in one clk; memories are loaded hierarchically.

module instruction_memory #(
    parameter int unsigned WORDS = 256,
    parameter int unsigned AW    = 8
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [31:0]   i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [31:0]   o_rdata
);
    logic [31:0] mem_array [0:WORDS-1];

    // Optional program-load port; the core ties it off and code is loaded hierarchically.
    always_ff @(posedge clk) begin
        if (i_we) mem_array[i_waddr] <= i_wdata;
    end

    assign o_rdata = mem_array[i_raddr];
endmodule

module data_memory #(
    parameter int unsigned WORDS = 256,
    parameter int unsigned AW    = 8
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);
    logic [31:0] mem_array [0:WORDS-1];

    always_ff @(posedge clk) begin
        if (i_we) mem_array[i_addr] <= i_wdata;
    end

    assign o_rdata = mem_array[i_addr];
endmodule

module mips32_core #(
    parameter int unsigned IMEM_WORDS = 256,
    parameter int unsigned DMEM_WORDS = 256
) (
    input logic clk,
    input logic reset
);
    localparam int unsigned IMEM_AW = $clog2(IMEM_WORDS);
    localparam int unsigned DMEM_AW = $clog2(DMEM_WORDS);

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_NOR  = 4'd5;
    localparam logic [3:0] ALU_SLT  = 4'd6;
    localparam logic [3:0] ALU_SLTU = 4'd7;
    localparam logic [3:0] ALU_SLL  = 4'd8;
    localparam logic [3:0] ALU_SRL  = 4'd9;
    localparam logic [3:0] ALU_SRA  = 4'd10;
    localparam logic [3:0] ALU_PASSB = 4'd11;

    localparam logic [1:0] DST_RT    = 2'd0;
    localparam logic [1:0] DST_RD    = 2'd1;
    localparam logic [1:0] DST_RA    = 2'd2;
    localparam logic [1:0] DST_RD_RA = 2'd3;

    localparam logic [1:0] BR_NONE = 2'd0;
    localparam logic [1:0] BR_EQ   = 2'd1;
    localparam logic [1:0] BR_NE   = 2'd2;

    localparam logic [1:0] WB_ALU  = 2'd0;
    localparam logic [1:0] WB_MEM  = 2'd1;
    localparam logic [1:0] WB_LINK = 2'd2;

    localparam logic [1:0] EXT_SIGN = 2'd0;
    localparam logic [1:0] EXT_ZERO = 2'd1;
    localparam logic [1:0] EXT_LUI  = 2'd2;

    logic [31:0] r_pc;
    logic [31:0] r_regfile [0:31];

    logic [31:0] current_pc, instruction_register;
    logic [3:0]  ALUOp;
    logic [1:0]  DstReg, BranchCondition, MemtoReg;
    logic        RegWrite, ALUSrcB, Jump, MemWrite, JumpReg, PCSrc;
    logic [31:0] regA_data_ex, regB_data_ex, alu_result, imm_extended, write_data;
    logic [4:0]  setAddress;
    logic [31:0] MemReadData;

    logic [5:0]  w_opcode, w_funct;
    logic [4:0]  w_rs, w_rt, w_rd, w_shamt;
    logic [15:0] w_imm;
    logic [25:0] w_target;
    logic [1:0]  w_ext_mode;
    logic [31:0] w_alu_b, w_pc_plus4, w_branch_target, w_jump_target, w_next_pc;

    assign current_pc = r_pc;

    instruction_memory #(.WORDS(IMEM_WORDS), .AW(IMEM_AW)) instruction_memory0 (
        .clk     (clk),
        .i_we    (1'b0),
        .i_waddr ('0),
        .i_wdata ('0),
        .i_raddr (r_pc[IMEM_AW+1:2]),
        .o_rdata (instruction_register)
    );

    assign w_opcode = instruction_register[31:26];
    assign w_rs     = instruction_register[25:21];
    assign w_rt     = instruction_register[20:16];
    assign w_rd     = instruction_register[15:11];
    assign w_shamt  = instruction_register[10:6];
    assign w_funct  = instruction_register[5:0];
    assign w_imm    = instruction_register[15:0];
    assign w_target = instruction_register[25:0];

    // Control decode; anything not listed falls through to the all-quiet nop defaults.
    always_comb begin
        ALUOp           = ALU_ADD;
        DstReg          = DST_RT;
        RegWrite        = 1'b0;
        ALUSrcB         = 1'b0;
        BranchCondition = BR_NONE;
        Jump            = 1'b0;
        MemtoReg        = WB_ALU;
        MemWrite        = 1'b0;
        JumpReg         = 1'b0;
        w_ext_mode      = EXT_SIGN;
        case (w_opcode)
            6'h00: begin
                DstReg = DST_RD;
                case (w_funct)
                    6'h20, 6'h21: begin RegWrite = 1'b1; ALUOp = ALU_ADD;  end
                    6'h22, 6'h23: begin RegWrite = 1'b1; ALUOp = ALU_SUB;  end
                    6'h24:        begin RegWrite = 1'b1; ALUOp = ALU_AND;  end
                    6'h25:        begin RegWrite = 1'b1; ALUOp = ALU_OR;   end
                    6'h26:        begin RegWrite = 1'b1; ALUOp = ALU_XOR;  end
                    6'h27:        begin RegWrite = 1'b1; ALUOp = ALU_NOR;  end
                    6'h2A:        begin RegWrite = 1'b1; ALUOp = ALU_SLT;  end
                    6'h2B:        begin RegWrite = 1'b1; ALUOp = ALU_SLTU; end
                    6'h00:        begin RegWrite = 1'b1; ALUOp = ALU_SLL;  end
                    6'h02:        begin RegWrite = 1'b1; ALUOp = ALU_SRL;  end
                    6'h03:        begin RegWrite = 1'b1; ALUOp = ALU_SRA;  end
                    6'h08:        JumpReg = 1'b1;
                    6'h09: begin
                        JumpReg  = 1'b1;
                        RegWrite = 1'b1;
                        DstReg   = DST_RD_RA;
                        MemtoReg = WB_LINK;
                    end
                    default: ;
                endcase
            end
            6'h04: BranchCondition = BR_EQ;
            6'h05: BranchCondition = BR_NE;
            6'h08, 6'h09: begin RegWrite = 1'b1; ALUSrcB = 1'b1; end
            6'h0A: begin RegWrite = 1'b1; ALUSrcB = 1'b1; ALUOp = ALU_SLT; end
            6'h0C: begin RegWrite = 1'b1; ALUSrcB = 1'b1; ALUOp = ALU_AND; w_ext_mode = EXT_ZERO; end
            6'h0D: begin RegWrite = 1'b1; ALUSrcB = 1'b1; ALUOp = ALU_OR;  w_ext_mode = EXT_ZERO; end
            6'h0E: begin RegWrite = 1'b1; ALUSrcB = 1'b1; ALUOp = ALU_XOR; w_ext_mode = EXT_ZERO; end
            6'h0F: begin RegWrite = 1'b1; ALUSrcB = 1'b1; ALUOp = ALU_PASSB; w_ext_mode = EXT_LUI; end
            6'h23: begin RegWrite = 1'b1; ALUSrcB = 1'b1; MemtoReg = WB_MEM; end
            6'h2B: begin ALUSrcB = 1'b1; MemWrite = 1'b1; end
            6'h02: Jump = 1'b1;
            6'h03: begin Jump = 1'b1; RegWrite = 1'b1; DstReg = DST_RA; MemtoReg = WB_LINK; end
            default: ;
        endcase
    end

    assign regA_data_ex = (w_rs == 5'd0) ? 32'd0 : r_regfile[w_rs];
    assign regB_data_ex = (w_rt == 5'd0) ? 32'd0 : r_regfile[w_rt];

    always_comb begin
        case (w_ext_mode)
            EXT_ZERO: imm_extended = {16'd0, w_imm};
            EXT_LUI:  imm_extended = {w_imm, 16'd0};
            default:  imm_extended = {{16{w_imm[15]}}, w_imm};
        endcase
    end

    assign w_alu_b = ALUSrcB ? imm_extended : regB_data_ex;

    // Shifts operate on the rt operand by shamt; lui simply passes the shifted immediate.
    always_comb begin
        case (ALUOp)
            ALU_SUB:   alu_result = regA_data_ex - w_alu_b;
            ALU_AND:   alu_result = regA_data_ex & w_alu_b;
            ALU_OR:    alu_result = regA_data_ex | w_alu_b;
            ALU_XOR:   alu_result = regA_data_ex ^ w_alu_b;
            ALU_NOR:   alu_result = ~(regA_data_ex | w_alu_b);
            ALU_SLT:   alu_result = {31'd0, $signed(regA_data_ex) < $signed(w_alu_b)};
            ALU_SLTU:  alu_result = {31'd0, regA_data_ex < w_alu_b};
            ALU_SLL:   alu_result = w_alu_b << w_shamt;
            ALU_SRL:   alu_result = w_alu_b >> w_shamt;
            ALU_SRA:   alu_result = 32'($signed(w_alu_b) >>> w_shamt);
            ALU_PASSB: alu_result = w_alu_b;
            default:   alu_result = regA_data_ex + w_alu_b;
        endcase
    end

    data_memory #(.WORDS(DMEM_WORDS), .AW(DMEM_AW)) data_memory0 (
        .clk     (clk),
        .i_we    (MemWrite & ~reset),
        .i_addr  (alu_result[DMEM_AW+1:2]),
        .i_wdata (regB_data_ex),
        .o_rdata (MemReadData)
    );

    assign w_pc_plus4 = r_pc + 32'd4;

    always_comb begin
        case (MemtoReg)
            WB_MEM:  write_data = MemReadData;
            WB_LINK: write_data = w_pc_plus4;
            default: write_data = alu_result;
        endcase
    end

    // jalr with rd=0 links into $31 rather than vanishing into $0.
    always_comb begin
        case (DstReg)
            DST_RD:    setAddress = w_rd;
            DST_RA:    setAddress = 5'd31;
            DST_RD_RA: setAddress = (w_rd == 5'd0) ? 5'd31 : w_rd;
            default:   setAddress = w_rt;
        endcase
    end

    assign PCSrc = ((BranchCondition == BR_EQ) && (regA_data_ex == regB_data_ex)) ||
                   ((BranchCondition == BR_NE) && (regA_data_ex != regB_data_ex));

    assign w_branch_target = w_pc_plus4 + {imm_extended[29:0], 2'b00};
    assign w_jump_target   = {w_pc_plus4[31:28], w_target, 2'b00};
    assign w_next_pc = JumpReg ? regA_data_ex :
                       Jump    ? w_jump_target :
                       PCSrc   ? w_branch_target : w_pc_plus4;

    always_ff @(posedge clk) begin
        if (reset) r_pc <= 32'd0;
        else       r_pc <= w_next_pc;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) r_regfile[i] <= 32'd0;
        end else if (RegWrite && (setAddress != 5'd0)) begin
            r_regfile[setAddress] <= write_data;
        end
    end
endmodule

// File: tb/tb_mips32_core.sv
// Directed programs for mips32_core: reset, loop, ALU sweep, jumps, $0, mid-run reset.

module tb_mips32_core;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;
    logic [31:0] prog [$];

    localparam logic [31:0] SENT = 32'hCCCC_CCCC;

    mips32_core #(.IMEM_WORDS(256), .DMEM_WORDS(256)) dut (
        .clk   (clk),
        .reset (reset)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd,
                                          input int sh, input int fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
    endfunction

    function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic logic [31:0] enc_j(input int op, input int target);
        return {6'(op), 26'(target)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic load_prog();
        for (int i = 0; i < 256; i++) dut.instruction_memory0.mem_array[i] = 32'd0;
        for (int i = 0; i < prog.size(); i++) dut.instruction_memory0.mem_array[i] = prog[i];
        prog.delete();
    endtask

    task automatic fill_dmem(input logic [31:0] v);
        for (int i = 0; i < 256; i++) dut.data_memory0.mem_array[i] = v;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One reset edge then release; called at a negedge.
    task automatic pulse_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic push_countdown();
        prog.push_back(enc_i(8'h08, 0, 1, 10));        // addi $1,$0,10
        prog.push_back(enc_i(8'h08, 0, 4, 1));         // addi $4,$0,1
        prog.push_back(enc_r(0, 1, 3, 2, 8'h00));      // loop: sll $3,$1,2
        prog.push_back(enc_i(8'h2B, 3, 1, 0));         // sw  $1,0($3)
        prog.push_back(enc_i(8'h23, 3, 5, 0));         // lw  $5,0($3)
        prog.push_back(enc_r(6, 5, 6, 0, 8'h20));      // add $6,$6,$5
        prog.push_back(enc_r(1, 4, 1, 0, 8'h22));      // sub $1,$1,$4
        prog.push_back(enc_i(8'h05, 1, 0, -6));        // bne $1,$0,loop
        prog.push_back(enc_i(8'h04, 0, 0, -1));        // halt: beq $0,$0,halt
        prog.push_back(32'd0);
    endtask

    logic [31:0] acc;
    logic [31:0] alu_exp [0:20];

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;

        // Reset hold: a store of $0 sits at PC 0 and must never fire while reset is high.
        prog.push_back(enc_i(8'h2B, 0, 0, 20));        // sw $0,20($0)
        load_prog();
        fill_dmem(32'd0);
        dut.data_memory0.mem_array[5] = 32'hDEAD_BEEF;
        cycles(2);
        chk("reset_pc", dut.current_pc, 32'd0);
        acc = 32'd0;
        for (int i = 0; i < 32; i++) acc = acc | dut.r_regfile[i];
        chk("reset_regs", acc, 32'd0);
        chk("reset_dmem_kept", dut.data_memory0.mem_array[5], 32'hDEAD_BEEF);

        // Countdown loop storing 1..10.
        reset = 1'b1;
        push_countdown();
        load_prog();
        fill_dmem(SENT);
        pulse_reset();
        cycles(80);
        for (int i = 1; i <= 10; i++)
            chk($sformatf("loop_dmem%0d", i), dut.data_memory0.mem_array[i], 32'(i));
        chk("loop_dmem0", dut.data_memory0.mem_array[0], SENT);
        chk("loop_dmem11", dut.data_memory0.mem_array[11], SENT);
        chk("loop_sum", dut.r_regfile[6], 32'd55);
        chk("loop_r1", dut.r_regfile[1], 32'd0);
        chk("loop_halt_pc", dut.current_pc, 32'd32);

        // ALU sweep: each result stored to consecutive words.
        reset = 1'b1;
        prog.push_back(enc_i(8'h08, 0, 1, 15));        // $1 = 0x0000000F
        prog.push_back(enc_i(8'h08, 0, 2, -16));       // $2 = 0xFFFFFFF0
        prog.push_back(enc_r(1, 2, 3, 0, 8'h20)); alu_exp[0]  = 32'hFFFF_FFFF; // add
        prog.push_back(enc_r(1, 2, 3, 0, 8'h24)); alu_exp[1]  = 32'h0000_0000; // and
        prog.push_back(enc_r(1, 2, 3, 0, 8'h27)); alu_exp[2]  = 32'h0000_0000; // nor
        prog.push_back(enc_r(1, 2, 3, 0, 8'h2A)); alu_exp[3]  = 32'h0000_0000; // slt
        prog.push_back(enc_r(1, 2, 3, 0, 8'h2B)); alu_exp[4]  = 32'h0000_0001; // sltu
        prog.push_back(enc_r(0, 2, 3, 4, 8'h03)); alu_exp[5]  = 32'hFFFF_FFFF; // sra 4
        prog.push_back(enc_r(0, 2, 3, 4, 8'h02)); alu_exp[6]  = 32'h0FFF_FFFF; // srl 4
        prog.push_back(enc_i(8'h0F, 0, 3, 16'h1234)); alu_exp[7] = 32'h1234_0000; // lui
        prog.push_back(enc_r(1, 2, 3, 0, 8'h22)); alu_exp[8]  = 32'h0000_001F; // sub
        prog.push_back(enc_r(1, 2, 3, 0, 8'h25)); alu_exp[9]  = 32'hFFFF_FFFF; // or
        prog.push_back(enc_r(1, 2, 3, 0, 8'h26)); alu_exp[10] = 32'hFFFF_FFFF; // xor
        prog.push_back(enc_r(2, 1, 3, 0, 8'h2A)); alu_exp[11] = 32'h0000_0001; // slt signed
        prog.push_back(enc_r(0, 1, 3, 4, 8'h00)); alu_exp[12] = 32'h0000_00F0; // sll 4
        prog.push_back(enc_i(8'h0D, 2, 3, 16'h8001)); alu_exp[13] = 32'hFFFF_FFF1; // ori zext
        prog.push_back(enc_i(8'h0C, 2, 3, 16'hFFFF)); alu_exp[14] = 32'h0000_FFF0; // andi zext
        prog.push_back(enc_i(8'h0A, 2, 3, -1));   alu_exp[15] = 32'h0000_0001; // slti
        prog.push_back(enc_i(8'h0E, 1, 3, 16'hFFFF)); alu_exp[16] = 32'h0000_FFF0; // xori
        prog.push_back(enc_i(8'h09, 1, 3, -1));   alu_exp[17] = 32'h0000_000E; // addiu
        prog.push_back(enc_r(2, 1, 3, 0, 8'h23)); alu_exp[18] = 32'hFFFF_FFE1; // subu
        prog.push_back(enc_r(1, 1, 3, 0, 8'h21)); alu_exp[19] = 32'h0000_001E; // addu
        alu_exp[20] = 32'h0000_001E;                   // unsupported ops must leave $3 alone
        prog.push_back(enc_i(8'h20, 0, 3, 0));         // lb (unsupported)
        prog.push_back(enc_r(1, 2, 3, 0, 8'h18));      // mult (unsupported funct)
        for (int k = 0; k <= 20; k++) begin
            logic [31:0] op;
            op = prog[2 + k];
            if (k < 20) begin
                prog[2 + k] = op;
            end
        end
        begin
            // Interleave one sw $3 after each result-producing instruction.
            logic [31:0] body [$];
            body.push_back(prog[0]);
            body.push_back(prog[1]);
            for (int k = 0; k < 20; k++) begin
                body.push_back(prog[2 + k]);
                body.push_back(enc_i(8'h2B, 0, 3, 4 * k));
            end
            body.push_back(prog[22]);
            body.push_back(prog[23]);
            body.push_back(enc_i(8'h2B, 0, 3, 80));
            body.push_back(enc_i(8'h04, 0, 0, -1));
            prog = body;
        end
        load_prog();
        fill_dmem(SENT);
        pulse_reset();
        cycles(60);
        for (int k = 0; k <= 20; k++)
            chk($sformatf("alu_word%0d", k), dut.data_memory0.mem_array[k], alu_exp[k]);

        // Jumps: jal -> sub1, jalr -> sub2, jr back twice, j over skipped code.
        reset = 1'b1;
        prog.push_back(enc_i(8'h08, 0, 10, 16'h55));   // 0: addi $10,$0,0x55
        prog.push_back(enc_j(8'h03, 6));               // 1: jal sub1
        prog.push_back(enc_i(8'h08, 0, 20, 1));        // 2: addi $20,$0,1
        prog.push_back(enc_j(8'h02, 10));              // 3: j end
        prog.push_back(enc_i(8'h08, 0, 21, 16'h99));   // 4: skipped
        prog.push_back(enc_i(8'h2B, 0, 21, 4));        // 5: skipped sw
        prog.push_back(enc_i(8'h08, 0, 8, 48));        // 6: sub1: addi $8,$0,48
        prog.push_back(enc_r(8, 0, 9, 0, 8'h09));      // 7: jalr $9,$8
        prog.push_back(enc_r(31, 0, 0, 0, 8'h08));     // 8: jr $31
        prog.push_back(enc_i(8'h08, 0, 22, 16'h77));   // 9: unreachable
        prog.push_back(enc_i(8'h2B, 0, 10, 0));        // 10: end: sw $10,0($0)
        prog.push_back(enc_i(8'h04, 0, 0, -1));        // 11: halt
        prog.push_back(enc_i(8'h08, 0, 11, 16'h33));   // 12: sub2
        prog.push_back(enc_r(9, 0, 0, 0, 8'h08));      // 13: jr $9
        load_prog();
        fill_dmem(SENT);
        pulse_reset();
        cycles(30);
        chk("jmp_marker", dut.data_memory0.mem_array[0], 32'h0000_0055);
        chk("jmp_ra", dut.r_regfile[31], 32'd8);
        chk("jmp_jalr_link", dut.r_regfile[9], 32'd32);
        chk("jmp_sub2_ran", dut.r_regfile[11], 32'h33);
        chk("jmp_return_ran", dut.r_regfile[20], 32'd1);
        chk("jmp_skip_r21", dut.r_regfile[21], 32'd0);
        chk("jmp_skip_r22", dut.r_regfile[22], 32'd0);
        chk("jmp_skip_sw", dut.data_memory0.mem_array[1], SENT);
        chk("jmp_halt_pc", dut.current_pc, 32'd44);

        // jalr with rd=0 links to $31; $0 write is discarded.
        reset = 1'b1;
        prog.push_back(enc_i(8'h08, 0, 8, 12));        // 0: addi $8,$0,12
        prog.push_back(enc_r(8, 0, 0, 0, 8'h09));      // 1: jalr $0,$8 -> $31
        prog.push_back(enc_i(8'h08, 0, 5, 1));         // 2: skipped
        prog.push_back(enc_i(8'h08, 0, 0, 5));         // 3: addi $0,$0,5
        prog.push_back(enc_i(8'h2B, 0, 0, 0));         // 4: sw $0,0($0)
        prog.push_back(enc_i(8'h04, 0, 0, -1));        // 5: halt
        load_prog();
        fill_dmem(SENT);
        pulse_reset();
        cycles(15);
        chk("zero_store", dut.data_memory0.mem_array[0], 32'd0);
        chk("zero_reg", dut.r_regfile[0], 32'd0);
        chk("jalr_rd0_ra", dut.r_regfile[31], 32'd8);
        chk("jalr_skip", dut.r_regfile[5], 32'd0);

        // Mid-run reset right when sw $1 (=9) to word 9 is the current instruction.
        reset = 1'b1;
        push_countdown();
        load_prog();
        fill_dmem(SENT);
        pulse_reset();
        cycles(9);
        chk("mid_pc_before", dut.current_pc, 32'd12);
        chk("mid_r1_before", dut.r_regfile[1], 32'd9);
        pulse_reset();
        chk("mid_pc_after", dut.current_pc, 32'd0);
        acc = dut.r_regfile[1] | dut.r_regfile[3] | dut.r_regfile[4] | dut.r_regfile[6];
        chk("mid_regs_cleared", acc, 32'd0);
        chk("mid_no_store", dut.data_memory0.mem_array[9], SENT);
        chk("mid_prior_store", dut.data_memory0.mem_array[10], 32'd10);
        cycles(80);
        chk("mid_rerun_dmem9", dut.data_memory0.mem_array[9], 32'd9);
        chk("mid_rerun_sum", dut.r_regfile[6], 32'd55);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
